// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported word memory.
// One transaction in flight: grant in IDLE, strobe in CMD, completion after RESP.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic              last_owner_q;
  logic              cmd_we_q;
  logic              cmd_owner_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              p0_done_q;
  logic              p1_done_q;
  logic              mem_wen_q;
  logic              mem_ren_q;

  logic              idle;
  logic              p0_win;
  logic              p1_win;
  logic              any_gnt;
  logic              cmd_we_d;
  logic              cmd_owner_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_d;

  // On a tie the port that did not own the previous grant wins.
  always_comb begin
    idle        = (state_q == IDLE);
    p0_win      = p0_req && (!p1_req || last_owner_q);
    p1_win      = p1_req && (!p0_req || !last_owner_q);
    p0_gnt      = idle && p0_win;
    p1_gnt      = idle && p1_win && !p0_win;
    any_gnt     = p0_gnt || p1_gnt;
    cmd_owner_d = p1_gnt;
    cmd_we_d    = p1_gnt ? p1_we    : p0_we;
    cmd_addr_d  = p1_gnt ? p1_addr  : p0_addr;
    cmd_wdata_d = p1_gnt ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      cmd_we_q     <= 1'b0;
      cmd_owner_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rdata_q      <= '0;
      p0_done_q    <= 1'b0;
      p1_done_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_ren_q    <= 1'b0;
    end else begin
      p0_done_q <= 1'b0;
      p1_done_q <= 1'b0;
      mem_wen_q <= 1'b0;
      mem_ren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_gnt) begin
            cmd_we_q     <= cmd_we_d;
            cmd_owner_q  <= cmd_owner_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            last_owner_q <= cmd_owner_d;
            // Strobes are registered so they are high for exactly the CMD cycle.
            mem_wen_q    <= cmd_we_d;
            mem_ren_q    <= !cmd_we_d;
            state_q      <= CMD;
          end
        end
        CMD: begin
          state_q <= RESP;
        end
        RESP: begin
          if (!cmd_we_q) begin
            rdata_q <= mem_rdata;
          end
          p0_done_q <= !cmd_owner_q;
          p1_done_q <= cmd_owner_q;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign p0_done   = p0_done_q;
  assign p1_done   = p1_done_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign mem_wen   = mem_wen_q;
  assign mem_ren   = mem_ren_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-ported `NextMemory` word interface between the core's fetch/load-store port (port 0) and a second bus master (port 1; the debug/program loader). It serialises requests, issues exactly one memory strobe per granted transaction and returns completion and read data to the owning requester. It sits between the requesters and `NextMemory`, driving that memory's wen/ren/addr/wdata.

## Interface
- ADDR_W, 16, word address width (byte address [17:2])
- DATA_W, 32, data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- p0_req  in  1  port 0 request; held until p0_gnt
- p0_we  in  1  port 0 direction, 1 = write, 0 = read
- p0_addr  in  ADDR_W  port 0 word address
- p0_wdata  in  DATA_W  port 0 write data
- p0_gnt  out  1  port 0 request accepted this cycle (combinational)
- p0_done  out  1  port 0 transaction complete (registered, 1-cycle pulse)
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done: same for port 1
- rdata  out  DATA_W  read data of the last completed read (registered)
- busy  out  1  state != IDLE
- mem_wen  out  1  memory write strobe
- mem_ren  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_ren

## Operation
- States: IDLE, CMD, RESP.
- IDLE: if any req, select winner, assert its gnt combinationally, latch we/addr/wdata and owner into command registers, go to CMD. No req: stay.
- Winner: single requester wins. Both requesting: port != last_owner wins; last_owner updated to winner at grant.
- CMD: mem_ren = !cmd_we, mem_wen = cmd_we for exactly this cycle; mem_addr/mem_wdata from command registers. Go to RESP.
- RESP: on read, capture mem_rdata into rdata at the edge ending RESP; on write, rdata unchanged. Set done register of owner. Go to IDLE.
- pX_done high in the cycle after RESP (state IDLE), for one cycle.
- Requests are never granted in CMD or RESP; gnt is 0 there and requester must hold req. Req inputs sampled only in IDLE; changes to addr/wdata/we after gnt have no effect on the transaction.
- mem_addr/mem_wdata hold command-register values outside CMD; mem_wen/mem_ren are 0 outside CMD.
- No buffering: at most one transaction in flight.

## Timing
- Reset (rst low, asynchronous): state IDLE, last_owner = 1 (port 0 wins first tie), all outputs 0 including rdata, mem_addr, mem_wdata, both done. In-flight transaction dropped: no strobe, no done after release.
- Reset asserted in CMD: strobe deasserts immediately with reset.
- Grant in cycle N: strobe N+1, mem_rdata sampled end of N+2, done and rdata valid in N+3.
- Next grant possible in N+3 (same cycle as previous done): peak one transaction per 3 cycles; a pending req at both ports with continuous assertion alternates 0,1,0,1.
- gnt and done never both asserted for the same port in the same cycle unless a new request is accepted in the done cycle (allowed).
- Exactly one of p0_gnt/p1_gnt/none per cycle; at most one done per cycle.

## Test plan
- Reset then p0 read addr 0x0004 (memory holds 0xDEADBEEF): p0_gnt cycle 0, mem_ren=1 addr 0x0004 cycle 1, p0_done=1, rdata=0xDEADBEEF cycle 3; p1_done stays 0.
- p1 write addr 0x0010 data 0x12345678, then p0 read 0x0010: mem_wen one cycle with those values, p1_done, rdata unchanged after write; subsequent read returns 0x12345678.
- Both req held continuously from reset, reads to 0x0001/0x0002: grants p0,p1,p0,p1 at cycles 0,3,6,9; each done 3 cycles after its grant to the correct port.
- p1 requests in CMD of a p0 transaction: p1_gnt=0 until IDLE (cycle 3), then p1 granted; changing p0_addr after gnt does not alter mem_addr.
- Assert rst low during CMD of a write: mem_wen drops asynchronously, all outputs 0; after release no done pulse, next tie goes to port 0.
- Idle with no requests for 10 cycles: busy=0, no strobes, mem_addr holds last value.
